// File: rtl/cmd_reg_bridge.sv
// Host command-frame to 32-bit register bus bridge with a 4-byte reply per frame (fx2_clk domain).
// Build option: define CMD_TIMEOUT_EN to abort partial frames after TIMEOUT idle cycles.
module cmd_reg_bridge #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              fx2_clk,
  input  logic              reset,
  input  logic [7:0]        cmd,
  input  logic              cmd_wr,
  output logic [7:0]        reply,
  output logic              reply_rdy,
  input  logic              reply_ack,
  output logic              reply_end,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [31:0]       reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [31:0]       reg_rdata,
  output logic              cmd_overrun,
  output logic              frame_err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR    = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_EXEC    = 3'd3;
  localparam logic [2:0] S_RD_WAIT = 3'd4;
  localparam logic [2:0] S_REPLY   = 3'd5;

  localparam logic [7:0] OP_READ  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;

  logic [2:0]        r_state;
  logic              r_is_write;
  logic [1:0]        r_idx;
  logic [1:0]        r_rbyte;
  logic [31:0]       r_word;
  logic [7:0]        r_reply;
  logic              r_reply_rdy;
  logic              r_reply_end;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wr;
  logic              r_rd;
  logic              r_overrun;
  logic              r_frame_err;
  logic [7:0]        r_lane [4];

  logic [7:0]        w_word_byte [4];
  logic [3:0]        w_lane_we;
  logic [1:0]        w_rbyte_nxt;
  logic              w_busy;
  logic              w_timeout;

  assign w_rbyte_nxt = r_rbyte + 2'd1;
  assign w_busy      = (r_state == S_EXEC) || (r_state == S_RD_WAIT) || (r_state == S_REPLY);

  // Write data is assembled one byte lane at a time, little-endian.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane_we[gi]        = (r_state == S_DATA) && cmd_wr && (r_idx == 2'(gi));
      assign w_word_byte[gi]      = r_word[8*gi +: 8];
      assign reg_wdata[8*gi +: 8] = r_lane[gi];

      always_ff @(posedge fx2_clk) begin
        if (reset) begin
          r_lane[gi] <= 8'h00;
        end else if (w_lane_we[gi]) begin
          r_lane[gi] <= cmd;
        end
      end
    end
  endgenerate

`ifdef CMD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] r_to_cnt;
  logic            w_in_frame;

  assign w_in_frame = (r_state == S_ADDR) || (r_state == S_DATA);
  // A byte arriving on the expiry cycle wins over the abort.
  assign w_timeout  = w_in_frame && !cmd_wr && (r_to_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge fx2_clk) begin
    if (reset || cmd_wr || !w_in_frame) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 0);
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge fx2_clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_is_write  <= 1'b0;
      r_idx       <= 2'd0;
      r_rbyte     <= 2'd0;
      r_word      <= 32'h0;
      r_reply     <= 8'h00;
      r_reply_rdy <= 1'b0;
      r_reply_end <= 1'b0;
      r_addr      <= '0;
      r_wr        <= 1'b0;
      r_rd        <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_wr <= 1'b0;
      r_rd <= 1'b0;
      if (cmd_wr && w_busy) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (cmd_wr) begin
            if ((cmd == OP_READ) || (cmd == OP_WRITE)) begin
              r_is_write <= (cmd == OP_WRITE);
              r_state    <= S_ADDR;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
        end
        S_ADDR: begin
          if (cmd_wr) begin
            r_addr <= cmd[ADDR_W-1:0];
            r_idx  <= 2'd0;
            if (r_is_write) begin
              r_state <= S_DATA;
            end else begin
              r_rd    <= 1'b1;
              r_state <= S_EXEC;
            end
          end else if (w_timeout) begin
            r_frame_err <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        S_DATA: begin
          if (cmd_wr) begin
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              r_wr    <= 1'b1;
              r_state <= S_EXEC;
            end
          end else if (w_timeout) begin
            r_frame_err <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        S_EXEC: begin
          // Strobe is high for this one cycle; writes echo their data back.
          if (r_is_write) begin
            r_word      <= reg_wdata;
            r_reply     <= reg_wdata[7:0];
            r_rbyte     <= 2'd0;
            r_reply_rdy <= 1'b1;
            r_reply_end <= 1'b0;
            r_state     <= S_REPLY;
          end else begin
            r_state <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          r_word      <= reg_rdata;
          r_reply     <= reg_rdata[7:0];
          r_rbyte     <= 2'd0;
          r_reply_rdy <= 1'b1;
          r_reply_end <= 1'b0;
          r_state     <= S_REPLY;
        end
        S_REPLY: begin
          if (reply_ack) begin
            if (r_rbyte == 2'd3) begin
              r_reply     <= 8'h00;
              r_reply_rdy <= 1'b0;
              r_reply_end <= 1'b0;
              r_state     <= S_IDLE;
            end else begin
              r_rbyte     <= w_rbyte_nxt;
              r_reply     <= w_word_byte[w_rbyte_nxt];
              r_reply_end <= (w_rbyte_nxt == 2'd3);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign reply       = r_reply;
  assign reply_rdy   = r_reply_rdy;
  assign reply_end   = r_reply_end;
  assign reg_addr    = r_addr;
  assign reg_wr      = r_wr;
  assign reg_rd      = r_rd;
  assign cmd_overrun = r_overrun;
  assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_cmd_reg_bridge.sv
// Directed bench for cmd_reg_bridge: write, read, bad opcode, overrun, mid-frame reset, optional timeout.
module tb_cmd_reg_bridge;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 16;

  logic              fx2_clk = 1'b0;
  logic              reset   = 1'b1;
  logic [7:0]        cmd     = 8'h00;
  logic              cmd_wr  = 1'b0;
  logic [7:0]        reply;
  logic              reply_rdy;
  logic              reply_ack = 1'b0;
  logic              reply_end;
  logic [ADDR_W-1:0] reg_addr;
  logic [31:0]       reg_wdata;
  logic              reg_wr;
  logic              reg_rd;
  logic [31:0]       reg_rdata = 32'hBAD0_BAD0;
  logic              cmd_overrun;
  logic              frame_err;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_wr  = 0;
  int          n_rd  = 0;
  logic [31:0] rd_value = 32'h0;
  logic        rd_pending = 1'b0;

  cmd_reg_bridge #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .fx2_clk    (fx2_clk),
    .reset      (reset),
    .cmd        (cmd),
    .cmd_wr     (cmd_wr),
    .reply      (reply),
    .reply_rdy  (reply_rdy),
    .reply_ack  (reply_ack),
    .reply_end  (reply_end),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_wr     (reg_wr),
    .reg_rd     (reg_rd),
    .reg_rdata  (reg_rdata),
    .cmd_overrun(cmd_overrun),
    .frame_err  (frame_err)
  );

  always #5 fx2_clk = ~fx2_clk;

  // Register-bus model: rdata is valid only in the cycle after reg_rd.
  initial begin
    forever begin
      @(posedge fx2_clk);
      #1;
      reg_rdata  = rd_pending ? rd_value : 32'hBAD0_BAD0;
      rd_pending = reg_rd;
      if (reg_wr) n_wr++;
      if (reg_rd) n_rd++;
    end
  end

  task automatic tick();
    @(posedge fx2_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    cmd    = b;
    cmd_wr = 1'b1;
    tick();
    cmd_wr = 1'b0;
  endtask

  task automatic collect(input string tag, input logic [31:0] word, input int first);
    int waitc = 0;
    while (!reply_rdy && waitc < 20) begin
      tick();
      waitc++;
    end
    chk({tag, "_rdy"}, {31'b0, reply_rdy}, 32'd1);
    for (int i = first; i < 4; i++) begin
      chk($sformatf("%s_b%0d", tag, i), {24'b0, reply}, {24'b0, word[8*i +: 8]});
      chk($sformatf("%s_end%0d", tag, i), {31'b0, reply_end}, {31'b0, (i == 3)});
      reply_ack = 1'b1;
      tick();
      reply_ack = 1'b0;
    end
    chk({tag, "_rdy_drop"}, {31'b0, reply_rdy}, 32'd0);
    chk({tag, "_end_drop"}, {31'b0, reply_end}, 32'd0);
    $display("txn %s: reply word %h collected", tag, word);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_reply"}, {24'b0, reply}, 32'd0);
    chk({tag, "_flags"}, {26'b0, reply_rdy, reply_end, reg_wr, reg_rd, cmd_overrun, frame_err}, 32'd0);
    chk({tag, "_addr"}, {24'b0, reg_addr}, 32'd0);
    chk({tag, "_wdata"}, reg_wdata, 32'd0);
  endtask

  task automatic do_read(input string tag, input logic [7:0] addr, input logic [31:0] val);
    rd_value = val;
    send_byte(8'h01);
    send_byte(addr);
    chk({tag, "_rd_pulse"}, {31'b0, reg_rd}, 32'd1);
    chk({tag, "_rd_addr"}, {24'b0, reg_addr}, {24'b0, addr});
    tick();
    chk({tag, "_rd_once"}, {31'b0, reg_rd}, 32'd0);
    chk({tag, "_rdy_early"}, {31'b0, reply_rdy}, 32'd0);
    tick();
    chk({tag, "_rd_lat"}, {31'b0, reply_rdy}, 32'd1);
    collect(tag, val, 0);
  endtask

  initial begin
    int wr_before;
    int rd_before;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    chk_reset_outputs("rst");
    reset = 1'b0;
    tick();
    $display("txn reset: outputs checked");

    // Write 0x12345678 to 0x10
    send_byte(8'h02);
    send_byte(8'h10);
    send_byte(8'h78);
    send_byte(8'h56);
    send_byte(8'h34);
    chk("wr_no_early", {31'b0, reg_wr}, 32'd0);
    send_byte(8'h12);
    chk("wr_pulse", {31'b0, reg_wr}, 32'd1);
    chk("wr_addr", {24'b0, reg_addr}, 32'h10);
    chk("wr_data", reg_wdata, 32'h1234_5678);
    tick();
    chk("wr_once", {31'b0, reg_wr}, 32'd0);
    chk("wr_lat", {31'b0, reply_rdy}, 32'd1);
    collect("write", 32'h1234_5678, 0);
    chk("wr_count", n_wr, 32'd1);
    chk("wdata_hold", reg_wdata, 32'h1234_5678);

    // Read 0x05
    do_read("read", 8'h05, 32'hDEAD_BEEF);
    chk("rd_no_err", {30'b0, cmd_overrun, frame_err}, 32'd0);

    // Bad opcode, then a normal read
    send_byte(8'h7F);
    chk("bad_ferr", {31'b0, frame_err}, 32'd1);
    tick();
    tick();
    chk("bad_no_reply", {31'b0, reply_rdy}, 32'd0);
    $display("txn badop: 7f dropped");
    do_read("read2", 8'h05, 32'hCAFE_F00D);

    // Overrun during REPLY
    chk("ovr_pre", {31'b0, cmd_overrun}, 32'd0);
    do_read("dummy", 8'h21, 32'h0102_0304);
    rd_value = 32'h1122_3344;
    send_byte(8'h01);
    send_byte(8'h20);
    tick();
    tick();
    chk("ovr_rdy", {31'b0, reply_rdy}, 32'd1);
    rd_before = n_rd;
    send_byte(8'h01);
    chk("ovr_flag", {31'b0, cmd_overrun}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("ovr_hold%0d", k), {23'b0, reply_rdy, reply}, 32'h144);
      tick();
    end
    // Ack and a byte together: ack wins, byte dropped
    cmd       = 8'h01;
    cmd_wr    = 1'b1;
    reply_ack = 1'b1;
    tick();
    cmd_wr    = 1'b0;
    reply_ack = 1'b0;
    collect("ovr", 32'h1122_3344, 1);
    for (int k = 0; k < 4; k++) tick();
    chk("ovr_no_frame", n_rd, rd_before);
    chk("ovr_idle", {31'b0, reply_rdy}, 32'd0);
    chk("ovr_addr", {24'b0, reg_addr}, 32'h20);

    // Reset in the middle of a write frame
    wr_before = n_wr;
    send_byte(8'h02);
    send_byte(8'h10);
    send_byte(8'hAA);
    reset = 1'b1;
    tick();
    chk_reset_outputs("midrst");
    reset = 1'b0;
    tick();
    do_read("post_rst", 8'h10, 32'h55AA_00FF);
    chk("midrst_no_wr", n_wr, wr_before);

`ifdef CMD_TIMEOUT_EN
    wr_before = n_wr;
    send_byte(8'h02);
    send_byte(8'h10);
    for (int k = 0; k < TIMEOUT - 1; k++) tick();
    chk("to_not_yet", {31'b0, frame_err}, 32'd0);
    for (int k = 0; k < 5; k++) tick();
    chk("to_ferr", {31'b0, frame_err}, 32'd1);
    chk("to_no_wr", n_wr, wr_before);
    chk("to_no_reply", {31'b0, reply_rdy}, 32'd0);
    $display("txn timeout: partial frame aborted");
    do_read("post_to", 8'h10, 32'hA5A5_5A5A);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
